bcd_serial_addsub: RTL and testbench



---
 rtl/bcd_serial_addsub.sv | 148 ++++++++++++++
 tb/tb_bcd_serial_addsub.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_addsub.sv
// Digit-serial BCD adder/subtractor: one decimal digit per clock, LSD first.
// Optional operand digit check (err port) enabled by defining BCD_DIGIT_CHECK_EN.
module bcd_serial_addsub #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sub,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   result,
  output logic                  cout
`ifdef BCD_DIGIT_CHECK_EN
  ,
  output logic                  err
`endif
);

  localparam int unsigned W     = 4 * DIGITS;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     a_q, b_q, acc_q, acc_d, result_q;
  logic [IDX_W-1:0] idx_q;
  logic             sub_q, c_q, c_d, cout_q;
  logic [3:0]       a_dig, b_dig, bd, dig;
  logic [4:0]       sum;
  logic             last_c;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (idx_q == LAST_IDX) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded from the state register
  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    unique case (state_q)
      IDLE:    ready = 1'b1;
      RUN:     busy  = 1'b1;
      DONE:    done  = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  // One digit step; subtraction uses the nine's complement of b plus the seeded carry
  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_dig = a_q[4*i +: 4];
        b_dig = b_q[4*i +: 4];
      end
    end
    bd  = sub_q ? 4'(4'd9 - b_dig) : b_dig;
    sum = 5'(a_dig) + 5'(bd) + 5'(c_q);
    if (sum > 5'd9) begin
      dig = 4'(sum + 5'd6);
      c_d = 1'b1;
    end else begin
      dig = sum[3:0];
      c_d = 1'b0;
    end
    acc_d = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) acc_d[4*i +: 4] = dig;
    end
  end

  assign last_c = (state_q == RUN) && (idx_q == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      idx_q    <= '0;
      sub_q    <= 1'b0;
      c_q      <= 1'b0;
      cout_q   <= 1'b0;
    end else begin
      if (state_q == IDLE && start) begin
        a_q   <= a;
        b_q   <= b;
        sub_q <= sub;
        c_q   <= sub ? ~cin : cin;
        idx_q <= '0;
        acc_q <= '0;
      end else if (state_q == RUN) begin
        acc_q <= acc_d;
        c_q   <= c_d;
        if (!last_c) idx_q <= idx_q + IDX_W'(1);
      end
      if (last_c) begin
        result_q <= acc_d;
        cout_q   <= sub_q ? ~c_d : c_d;
      end
    end
  end

  assign result = result_q;
  assign cout   = cout_q;

`ifdef BCD_DIGIT_CHECK_EN
  logic bad_flag_q, err_q, bad_dig;

  assign bad_dig = (a_dig > 4'd9) || (b_dig > 4'd9);

  // Sticky non-BCD flag, published alongside the result
  always_ff @(posedge clk) begin
    if (rst) begin
      bad_flag_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (state_q == IDLE && start)  bad_flag_q <= 1'b0;
      else if (state_q == RUN)       bad_flag_q <= bad_flag_q | bad_dig;
      if (last_c) err_q <= bad_flag_q | bad_dig;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Self-checking bench for bcd_serial_addsub: decimal reference model feeding an in-order scoreboard.
module tb_bcd_serial_addsub;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst, start, sub, cin;
  logic [W-1:0] a, b;
  logic         ready, busy, done, cout;
  logic [W-1:0] result;
`ifdef BCD_DIGIT_CHECK_EN
  logic         err;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  logic [W:0] exp_q[$];

  bcd_serial_addsub #(.DIGITS(DIGITS)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .cin    (cin),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout)
`ifdef BCD_DIGIT_CHECK_EN
    ,
    .err    (err)
`endif
  );

  always #5 clk = ~clk;

  // Reference: plain decimal arithmetic on whole numbers, returns {cout, result}
  function automatic logic [W:0] model(input logic s, input logic [W-1:0] x,
                                       input logic [W-1:0] y, input logic ci);
    longint ax = 0, ay = 0, p = 1, r;
    logic [W-1:0] res = '0;
    logic co;
    logic [3:0] d;
    for (int i = 0; i < DIGITS; i++) begin
      d = x[4*i +: 4]; ax += longint'(d) * p;
      d = y[4*i +: 4]; ay += longint'(d) * p;
      p *= 10;
    end
    if (!s) begin
      r  = ax + ay + longint'(ci);
      co = (r >= p);
      r  = r % p;
    end else begin
      r  = ax - ay - longint'(ci);
      co = (r < 0);
      if (r < 0) r += p;
    end
    for (int i = 0; i < DIGITS; i++) begin
      res[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return {co, res};
  endfunction

  // Scoreboard: every done pulse pops one expected result
  always @(negedge clk) begin
    if (done === 1'b1) begin
      n_assert++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: got cout=%b result=%h, no operation pending", cout, result);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        if ({cout, result} !== e) begin
          n_fail++;
          $display("FAIL scoreboard: got cout=%b result=%h, expected cout=%b result=%h",
                   cout, result, e[W], e[W-1:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one accepted operation in cycle 0; returns in cycle 1 with start low
  task automatic launch(input logic s, input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    sub = s; a = x; b = y; cin = ci; start = 1'b1;
    exp_q.push_back(model(s, x, y, ci));
    tick();
    start = 1'b0;
  endtask

  // Bounded wait for done; cyc is the cycle number (0 = acceptance) or -1 on timeout
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < 50) begin
      tick();
      cyc++;
    end
    if (done !== 1'b1) cyc = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; sub = 1'b0; a = 16'h1111; b = 16'h2222; cin = 1'b0;
    tick(); tick();
    start = 1'b0;
    rst = 1'b0;
    n_assert++;
    if ({ready, busy, done, cout, result} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
      n_fail++;
      $display("FAIL reset_values: got ready=%b busy=%b done=%b cout=%b result=%h, expected 1 0 0 0 0000",
               ready, busy, done, cout, result);
    end
  endtask

  task automatic test_vectors(input int kind);
    logic [W-1:0] va[5], vb[5];
    logic vs[5], vc[5];
    int cyc;
    logic [W:0] e;
    if (kind == 0) begin
      va = '{16'h1234, 16'h9999, 16'h0045, 16'h0500, 16'h0123};
      vb = '{16'h8766, 16'h0000, 16'h0037, 16'h0123, 16'h0500};
      vs = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      vc = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    end else begin
      for (int k = 0; k < 5; k++) begin
        for (int i = 0; i < DIGITS; i++) begin
          va[k][4*i +: 4] = 4'($urandom_range(0, 9));
          vb[k][4*i +: 4] = 4'($urandom_range(0, 9));
        end
        vs[k] = 1'($urandom_range(0, 1));
        vc[k] = 1'($urandom_range(0, 1));
      end
    end
    for (int k = 0; k < 5; k++) begin
      e = model(vs[k], va[k], vb[k], vc[k]);
      launch(vs[k], va[k], vb[k], vc[k]);
      n_assert++;
      if (busy !== 1'b1 || ready !== 1'b0) begin
        n_fail++;
        $display("FAIL run_status[%0d]: got busy=%b ready=%b, expected 1 0", k, busy, ready);
      end
      wait_done(cyc);
      n_assert++;
      if (cyc !== DIGITS + 1) begin
        n_fail++;
        $display("FAIL done_cycle[%0d]: got %0d, expected %0d", k, cyc, DIGITS + 1);
      end
      tick();
      n_assert++;
      if (ready !== 1'b1 || {cout, result} !== e) begin
        n_fail++;
        $display("FAIL hold[%0d]: got ready=%b cout=%b result=%h, expected ready=1 cout=%b result=%h",
                 k, ready, cout, result, e[W], e[W-1:0]);
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [W:0] e;
    e = model(1'b0, 16'h2468, 16'h1357, 1'b1);
    launch(1'b0, 16'h2468, 16'h1357, 1'b1);   // cycle 1
    tick();                                   // cycle 2: stray start while busy
    start = 1'b1; sub = 1'b1; a = 16'h9000; b = 16'h0001; cin = 1'b1;
    tick();                                   // cycle 3
    start = 1'b0;
    tick(); tick();                           // cycle 5: stray start while done
    n_assert++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL ignore_done_cycle: got done=%b in cycle 5, expected 1", done);
    end
    start = 1'b1;
    tick();                                   // cycle 6
    start = 1'b0;
    n_assert++;
    if (ready !== 1'b1 || busy !== 1'b0 || {cout, result} !== e) begin
      n_fail++;
      $display("FAIL ignore_after: got ready=%b busy=%b cout=%b result=%h, expected 1 0 %b %h",
               ready, busy, cout, result, e[W], e[W-1:0]);
    end
    tick();
    n_assert++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_no_launch: got busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    int first = -1, second = -1;
    sub = 1'b0; a = 16'h0999; b = 16'h0001; cin = 1'b0; start = 1'b1;
    exp_q.push_back(model(1'b0, 16'h0999, 16'h0001, 1'b0));
    exp_q.push_back(model(1'b1, 16'h0010, 16'h0020, 1'b1));
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (c == 1) begin sub = 1'b1; a = 16'h0010; b = 16'h0020; cin = 1'b1; end
      if (c == 7) start = 1'b0;
      if (done === 1'b1) begin
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
    end
    n_assert++;
    if (first !== 5 || second !== 11) begin
      n_fail++;
      $display("FAIL back_to_back: got done cycles %0d and %0d, expected 5 and 11", first, second);
    end
  endtask

  task automatic test_reset_midrun();
    bit saw_done = 0;
    launch(1'b0, 16'h5555, 16'h4444, 1'b0);   // cycle 1
    tick(); tick();                           // cycle 3
    rst = 1'b1;
    tick();                                   // cycle 4
    rst = 1'b0;
    n_assert++;
    if ({ready, busy, done, cout, result} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
      n_fail++;
      $display("FAIL midrun_reset: got ready=%b busy=%b done=%b cout=%b result=%h, expected 1 0 0 0 0000",
               ready, busy, done, cout, result);
    end
    void'(exp_q.pop_back());                  // aborted operation never reports
    repeat (10) begin
      tick();
      if (done === 1'b1) saw_done = 1;
    end
    n_assert++;
    if (saw_done) begin
      n_fail++;
      $display("FAIL midrun_no_done: got a done pulse after reset, expected none");
    end
  endtask

`ifdef BCD_DIGIT_CHECK_EN
  task automatic test_err();
    int cyc;
    sub = 1'b0; a = 16'h00A1; b = 16'h0001; cin = 1'b0; start = 1'b1;
    exp_q.push_back({1'b0, 16'h0102});
    tick();
    start = 1'b0;
    wait_done(cyc);
    n_assert++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_set: got err=%b, expected 1", err);
    end
    tick();
    launch(1'b0, 16'h0011, 16'h0022, 1'b0);
    wait_done(cyc);
    n_assert++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: got err=%b, expected 0", err);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_vectors(0);
    test_vectors(1);
    test_start_ignored();
    test_back_to_back();
    test_reset_midrun();
`ifdef BCD_DIGIT_CHECK_EN
    test_err();
`endif
    tick();
    n_assert++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending: got %0d results never reported, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
